// File: rtl/rst_pulse_gen_if.sv
// rst_pulse_gen_if: request/status bundle between a system controller (master) and rst_pulse_gen (slave).
// With RST_PULSE_GEN_COUNT_EN defined the bundle also carries the pulse counter.
interface rst_pulse_gen_if;
    logic req;
    logic rst_out;
    logic busy;
    logic done;
`ifdef RST_PULSE_GEN_COUNT_EN
    logic [7:0] pulse_cnt;
    modport master (output req, input rst_out, busy, done, pulse_cnt);
    modport slave (input req, output rst_out, busy, done, pulse_cnt);
`else
    modport master (output req, input rst_out, busy, done);
    modport slave (input req, output rst_out, busy, done);
`endif
endinterface

// File: rtl/rst_pulse_gen.sv
// rst_pulse_gen: stretches a reset request into a fixed-width active-low pulse followed by a recovery gap.
// Optional RST_PULSE_GEN_COUNT_EN adds a saturating count of request-initiated pulses.
module rst_pulse_gen #(
    parameter int PULSE_WIDTH     = 4,
    parameter int RECOVERY_CYCLES = 3,
    parameter int CNT_WIDTH       = 8
) (
    input logic             clk_i,
    input logic             rst_i,
    rst_pulse_gen_if.slave  bus
);
    if (PULSE_WIDTH < 1 || PULSE_WIDTH > 255 || RECOVERY_CYCLES < 1 || RECOVERY_CYCLES > 255 ||
        CNT_WIDTH < 1 || ((PULSE_WIDTH - 1) >> CNT_WIDTH) != 0 ||
        ((RECOVERY_CYCLES - 1) >> CNT_WIDTH) != 0) begin : g_bad_cfg
        $error("rst_pulse_gen: PULSE_WIDTH/RECOVERY_CYCLES out of range or too wide for CNT_WIDTH");
    end

    localparam logic [CNT_WIDTH-1:0] PW_M1 = CNT_WIDTH'(PULSE_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] RC_M1 = CNT_WIDTH'(RECOVERY_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ASSERT, RECOVER} state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 pend_q, pend_d;
    logic                 rst_out_q, rst_out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        rst_out_d = rst_out_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: if (bus.req) begin
                state_d   = ASSERT;
                cnt_d     = PW_M1;
                rst_out_d = 1'b0;
                busy_d    = 1'b1;
            end
            ASSERT: if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                state_d   = RECOVER;
                cnt_d     = RC_M1;
                rst_out_d = 1'b1;
            end
            RECOVER: begin
                pend_d = pend_q | bus.req;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (pend_q | bus.req) begin
                    // a request seen anywhere in the gap chains straight into the next pulse
                    state_d   = ASSERT;
                    cnt_d     = PW_M1;
                    rst_out_d = 1'b0;
                    pend_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ASSERT;
            cnt_q     <= PW_M1;
            pend_q    <= 1'b0;
            rst_out_q <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            rst_out_q <= rst_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.rst_out = rst_out_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

`ifdef RST_PULSE_GEN_COUNT_EN
    logic [7:0] pulse_cnt_q, pulse_cnt_d;
    logic       start;

    // reset-initiated pulses never pass through this transition, so they are not counted
    assign start       = (state_d == ASSERT) && (state_q != ASSERT);
    assign pulse_cnt_d = (start && pulse_cnt_q != 8'hFF) ? pulse_cnt_q + 8'd1 : pulse_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) pulse_cnt_q <= 8'd0;
        else       pulse_cnt_q <= pulse_cnt_d;
    end

    assign bus.pulse_cnt = pulse_cnt_q;
`endif
endmodule

// File: tb/tb_rst_pulse_gen.sv
// tb_rst_pulse_gen: random and directed stimulus for rst_pulse_gen, checked every cycle against a
// pulse-schedule model (start edge + offset arithmetic) and pinned by hand-computed waveforms.
module tb_rst_pulse_gen;
    localparam int PW = 4;
    localparam int RC = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_s, rst_s;
    int   checks = 0;
    int   failures = 0;

    rst_pulse_gen_if bus();

    rst_pulse_gen #(.PULSE_WIDTH(PW), .RECOVERY_CYCLES(RC), .CNT_WIDTH(8)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        req_s <= bus.req;
        rst_s <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a pulse is described by the edge it started on; everything follows from the offset.
    initial begin
        bit mvalid = 0, active = 0, pend = 0, exp_done = 0;
        int e = 0, start = 0, off = 0, mcnt = 0;
        forever begin
            @(negedge clk);
            e++;
            if (rst_s === 1'b1) begin
                mvalid = 1; active = 1; start = e; pend = 0; exp_done = 0; mcnt = 0;
            end else if (mvalid) begin
                exp_done = 0;
                if (!active) begin
                    if (req_s) begin
                        active = 1; start = e;
                        if (mcnt < 255) mcnt++;
                    end
                end else begin
                    off = e - start;
                    if (off > PW && req_s) pend = 1;
                    if (off == PW + RC) begin
                        if (pend) begin
                            start = e; pend = 0;
                            if (mcnt < 255) mcnt++;
                        end else begin
                            active = 0; exp_done = 1;
                        end
                    end
                end
            end
            if (mvalid) begin
                chk("model.rst_out", 32'(bus.rst_out), 32'(!(active && (e - start) < PW)));
                chk("model.busy", 32'(bus.busy), 32'(active));
                chk("model.done", 32'(bus.done), 32'(exp_done));
                chk("inv.done_busy", 32'(bus.done & bus.busy), 32'd0);
                chk("inv.done_rst_out", 32'(bus.done & ~bus.rst_out), 32'd0);
`ifdef RST_PULSE_GEN_COUNT_EN
                chk("model.pulse_cnt", 32'(bus.pulse_cnt), 32'(mcnt));
`endif
            end
        end
    end

    // Drives req/rst bit i before edge i and records the outputs seen after that edge.
    task automatic run_pin(input string name, input int n, input logic [31:0] rq, input logic [31:0] rs,
                           input logic [31:0] exp_ro, input logic [31:0] exp_bz, input logic [31:0] exp_dn);
        logic [31:0] a_ro = '0, a_bz = '0, a_dn = '0;
        for (int i = 0; i < n; i++) begin
            bus.req = rq[i];
            rst = rs[i];
            @(posedge clk);
            @(negedge clk);
            a_ro[i] = bus.rst_out;
            a_bz[i] = bus.busy;
            a_dn[i] = bus.done;
        end
        bus.req = 1'b0;
        rst = 1'b0;
        chk({name, ".rst_out"}, a_ro, exp_ro);
        chk({name, ".busy"}, a_bz, exp_bz);
        chk({name, ".done"}, a_dn, exp_dn);
    endtask

    initial begin
        int p, wait_n;
        bus.req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        run_pin("reset_release", 13, 32'h7, 32'h7, 32'h1FC0, 32'h01FF, 32'h0200);
        run_pin("single_req", 9, 32'h1, 32'h0, 32'h1F0, 32'h07F, 32'h080);
        run_pin("req_in_recover", 16, 32'h41, 32'h0, 32'hF870, 32'h3FFF, 32'h4000);
        run_pin("req_in_assert", 9, 32'h5, 32'h0, 32'h1F0, 32'h07F, 32'h080);
        run_pin("req_last_recover", 16, 32'h81, 32'h0, 32'hF870, 32'h3FFF, 32'h4000);
        run_pin("rst_mid_recover", 15, 32'h21, 32'h40, 32'h7C30, 32'h1FFF, 32'h2000);
`ifdef RST_PULSE_GEN_COUNT_EN
        chk("pulse_cnt_after_rst", 32'(bus.pulse_cnt), 32'd0);
        run_pin("single_req_a", 9, 32'h1, 32'h0, 32'h1F0, 32'h07F, 32'h080);
        run_pin("single_req_b", 9, 32'h1, 32'h0, 32'h1F0, 32'h07F, 32'h080);
        chk("pulse_cnt_two_req", 32'(bus.pulse_cnt), 32'd2);
`endif
        bus.req = 1'b1;
        repeat (20) @(negedge clk);
        bus.req = 1'b0;
        repeat (12) @(negedge clk);
        p = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                case ($urandom_range(4))
                    0: p = 0;
                    1: p = 5;
                    2: p = 30;
                    3: p = 90;
                    default: p = 100;
                endcase
            end
            bus.req = ($urandom_range(99) < p);
            rst = ($urandom_range(199) == 0);
            @(negedge clk);
        end
        bus.req = 1'b0;
        rst = 1'b0;
        wait_n = 0;
        while (bus.busy !== 1'b0 && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        chk("drain_timeout", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
